cube_panel_scanner: RTL and testbench
=====================================

Name: cube_panel_scanner

Overview:
- Parametrised LED-cube panel scan engine, successor to the fixed 4-panel/3-colour/16-row datapath.
- Holds a double-buffered frame store and accepts row-word writes from the USB side into the back buffer.
- Scans the front buffer row by row and drives serial data, serial clock, latch, output enable and active-low row selects.
- Front/back buffers swap only on a frame boundary.

Parameters:
- NUM_PANELS, 4, number of panels; one serial line per panel per colour.
- COLORS, 3, colour channels per panel.
- ROWS, 16, scanned rows per panel; power of two, at least 2.
- COLS, 16, bits shifted per serial line per row.
- CLK_DIV, 2, clk cycles per serial_clk half-period; at least 1.
- BLANK_CYCLES, 8, output-off cycles before each latch; at least 1.
- DISPLAY_CYCLES, 256, output-on cycles per row; at least 1.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- wr_en  in  1  write strobe for one row word into the back buffer.
- wr_panel  in  clog2(NUM_PANELS)  target panel.
- wr_row  in  clog2(ROWS)  target row.
- wr_color  in  clog2(COLORS)  target colour.
- wr_data  in  COLS  row bits; bit COLS-1 is shifted first.
- swap_req  in  1  level request to swap buffers at the next frame boundary.
- swap_ack  out  1  one-cycle pulse when the swap takes effect.
- frame_start  out  1  one-cycle pulse as the row-0 shift begins.
- serial_clk  out  1  shift clock to the panel drivers.
- latch_enable  out  1  driver latch strobe.
- output_enable_n  out  1  driver output enable, active low.
- serial_data_out  out  NUM_PANELS*COLORS  bit index p*COLORS+c.
- row_select_n  out  ROWS  one-hot active-low row drive.
- state_out  out  3  encoded current state, for debug LEDs.

Behaviour:
- Reset values: serial_clk 0, latch_enable 0, output_enable_n 1, row_select_n all 1, serial_data_out 0, swap_ack 0, frame_start 0, state SHIFT, row 0, bit counter COLS-1, front buffer index 0. Frame store contents are not reset.
- Reset is asynchronous assert, synchronous-release use. Reset mid-shift abandons the row; outputs return to reset values immediately.
- Writes: when wr_en=1 the word goes to back[wr_panel][wr_row][wr_color] at the next edge.
  - Out-of-range wr_panel or wr_color indices are ignored (no write).
  - Writes are never blocked. A write on the same cycle as a swap lands in the pre-swap back buffer.
- State machine, state_out encoding: SHIFT=0, BLANK=1, LATCH=2, DISPLAY=3.
  - SHIFT: serial_data_out presents bit b of front[p][row][c] for every line. serial_clk is low CLK_DIV cycles, then high CLK_DIV cycles; data changes only while serial_clk is low. After the high phase of bit 0, go to BLANK. One SHIFT takes 2*CLK_DIV*COLS cycles; the previous row stays lit during SHIFT.
  - BLANK: output_enable_n=1 for BLANK_CYCLES cycles, then go to LATCH.
  - LATCH: latch_enable=1 for exactly one cycle. row_select_n updates in the same cycle to drive the row just shifted. Then go to DISPLAY.
  - DISPLAY: output_enable_n=0 for DISPLAY_CYCLES cycles. Row pointer advances (wraps ROWS-1 to 0), then go to SHIFT.
- frame_start pulses on the first SHIFT cycle of row 0.
- Swap: on the transition from DISPLAY of row ROWS-1 into SHIFT of row 0, if swap_req=1, toggle the front index and pulse swap_ack in that same cycle.
  - swap_req held high swaps every frame.
  - swap_req asserted mid-frame waits for the frame end.
- Frame period: ROWS*(2*CLK_DIV*COLS + BLANK_CYCLES + 1 + DISPLAY_CYCLES) cycles.
- Before the first latch after reset, row_select_n stays all ones.

Optional Feature:
- Macro CUBE_TEST_PATTERN_EN.
- Defined: adds input test_pattern (1 bit, synchronised outside). While high, the shifted data is all ones on every line, regardless of buffer contents. Scanning, writes and swaps are otherwise unchanged.
- Undefined: no port and no logic; data always comes from the front buffer.

Decomposition:
- Shared package cube_pkg holds:
  - state enum (SHIFT/BLANK/LATCH/DISPLAY with the fixed encodings above);
  - default geometry constants NUM_PANELS_DEF, COLORS_DEF, ROWS_DEF, COLS_DEF;
  - a clog2-based width function.
- One sub-module, cube_frame_store: dual-bank memory with a write port into the back bank and a combinational read of the front bank. It is indexed by panel/colour/row and returns all NUM_PANELS*COLORS words for a row.

Test Plan:
- Reset mid-SHIFT (assert reset at cycle 10): outputs immediately output_enable_n=1, row_select_n=16'hFFFF, latch_enable=0, serial_clk=0.
- Write 16'hA5C3 to panel 2/row 0/colour 1, set swap_req=1, wait for swap_ack. Next row-0 shift on serial_data_out[7] shows 1010_0101_1100_0011 MSB-first, sampled on serial_clk rising edges. All other lines read 0.
- Defaults: measure cycles between frame_start pulses = 16*(64+8+1+256) = 5264. latch_enable high exactly 16 single cycles per frame.
- Row sequencing: after each LATCH, row_select_n cycles FFFE, FFFD, … 7FFF, then wraps to FFFE. Exactly one bit is low.
- Swap timing: assert swap_req during row 5. swap_ack arrives only at the row-15 to row-0 transition, coincident with frame_start. Writes issued during the frame do not appear until after the swap.
- With CUBE_TEST_PATTERN_EN and test_pattern=1: all 12 serial lines read 16'hFFFF for every row, independent of buffer contents.

Source files
------------

// File: rtl/cube_pkg.sv
// Shared types and geometry defaults for the LED-cube panel scanner.
package cube_pkg;

  typedef enum logic [2:0] {
    ST_SHIFT   = 3'd0,
    ST_BLANK   = 3'd1,
    ST_LATCH   = 3'd2,
    ST_DISPLAY = 3'd3
  } cube_state_e;

  localparam int NUM_PANELS_DEF = 4;
  localparam int COLORS_DEF     = 3;
  localparam int ROWS_DEF       = 16;
  localparam int COLS_DEF       = 16;

  function automatic int cube_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/cube_frame_store.sv
// Double-banked row-word store: writes go to one bank, the other bank
// is read combinationally one full row (all panel/colour lines) at a time.
module cube_frame_store
  import cube_pkg::*;
#(
  parameter int NUM_PANELS = NUM_PANELS_DEF,
  parameter int COLORS     = COLORS_DEF,
  parameter int ROWS       = ROWS_DEF,
  parameter int COLS       = COLS_DEF
) (
  input  logic                                clk,
  input  logic                                wr_en,
  input  logic                                wr_bank,
  input  logic [cube_w(NUM_PANELS)-1:0]       wr_panel,
  input  logic [cube_w(ROWS)-1:0]             wr_row,
  input  logic [cube_w(COLORS)-1:0]           wr_color,
  input  logic [COLS-1:0]                     wr_data,
  input  logic                                rd_bank,
  input  logic [cube_w(ROWS)-1:0]             rd_row,
  output logic [NUM_PANELS*COLORS-1:0][COLS-1:0] rd_words
);

  localparam int LINES = NUM_PANELS * COLORS;
  localparam int LW    = cube_w(LINES);
  localparam int PW    = cube_w(NUM_PANELS);
  localparam int CW    = cube_w(COLORS);

  logic [COLS-1:0] r_mem [2][LINES][ROWS];
  logic            w_ok;
  logic [LW-1:0]   w_line;

  // Out-of-range panel/colour codes are dropped rather than aliased
  assign w_ok = ({1'b0, wr_panel} < (PW+1)'(NUM_PANELS)) &&
                ({1'b0, wr_color} < (CW+1)'(COLORS));
  assign w_line = LW'(wr_panel) * LW'(COLORS) + LW'(wr_color);

  always_ff @(posedge clk) begin
    if (wr_en && w_ok)
      r_mem[wr_bank][w_line][wr_row] <= wr_data;
  end

  for (genvar g = 0; g < LINES; g++) begin : g_rd
    assign rd_words[g] = r_mem[rd_bank][g][rd_row];
  end

endmodule

// File: rtl/cube_panel_scanner.sv
// LED-cube panel scan engine: shift / blank / latch / display per row.
// CUBE_TEST_PATTERN_EN adds a test_pattern input forcing all-ones data.
module cube_panel_scanner
  import cube_pkg::*;
#(
  parameter int NUM_PANELS     = NUM_PANELS_DEF,
  parameter int COLORS         = COLORS_DEF,
  parameter int ROWS           = ROWS_DEF,
  parameter int COLS           = COLS_DEF,
  parameter int CLK_DIV        = 2,
  parameter int BLANK_CYCLES   = 8,
  parameter int DISPLAY_CYCLES = 256
) (
  input  logic                           clk,
  input  logic                           reset,
`ifdef CUBE_TEST_PATTERN_EN
  input  logic                           test_pattern,
`endif
  input  logic                           wr_en,
  input  logic [cube_w(NUM_PANELS)-1:0]  wr_panel,
  input  logic [cube_w(ROWS)-1:0]        wr_row,
  input  logic [cube_w(COLORS)-1:0]      wr_color,
  input  logic [COLS-1:0]                wr_data,
  input  logic                           swap_req,
  output logic                           swap_ack,
  output logic                           frame_start,
  output logic                           serial_clk,
  output logic                           latch_enable,
  output logic                           output_enable_n,
  output logic [NUM_PANELS*COLORS-1:0]   serial_data_out,
  output logic [ROWS-1:0]                row_select_n,
  output logic [2:0]                     state_out
);

  localparam int LINES = NUM_PANELS * COLORS;
  localparam int RW    = cube_w(ROWS);
  localparam int BW    = cube_w(COLS);
  localparam int DW    = cube_w(2 * CLK_DIV);
  localparam int NMAX  = (BLANK_CYCLES > DISPLAY_CYCLES) ?
                         BLANK_CYCLES : DISPLAY_CYCLES;
  localparam int NW    = cube_w(NMAX);

  localparam logic [DW-1:0] DIV_HALF  = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(2 * CLK_DIV - 1);
  localparam logic [NW-1:0] BLK_LAST  = NW'(BLANK_CYCLES - 1);
  localparam logic [NW-1:0] DSP_LAST  = NW'(DISPLAY_CYCLES - 1);
  localparam logic [BW-1:0] BIT_TOP   = BW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS - 1);

  cube_state_e     r_state;
  logic [RW-1:0]   r_row;
  logic [BW-1:0]   r_bit;
  logic [DW-1:0]   r_div;
  logic [NW-1:0]   r_cnt;
  logic            r_front;
  logic            r_prime;

  logic [RW-1:0]   w_nrow;
  logic [BW-1:0]   w_nbit;
  logic            w_nfront;
  logic            w_load;
  logic [LINES-1:0][COLS-1:0] w_words;
  logic [LINES-1:0] w_raw;
  logic [LINES-1:0] w_bits;

  cube_frame_store #(
    .NUM_PANELS (NUM_PANELS),
    .COLORS     (COLORS),
    .ROWS       (ROWS),
    .COLS       (COLS)
  ) u_store (
    .clk      (clk),
    .wr_en    (wr_en),
    .wr_bank  (~r_front),
    .wr_panel (wr_panel),
    .wr_row   (wr_row),
    .wr_color (wr_color),
    .wr_data  (wr_data),
    .rd_bank  (w_nfront),
    .rd_row   (w_nrow),
    .rd_words (w_words)
  );

  // Look one edge ahead so the data register is valid with the new bit
  always_comb begin
    w_nrow   = r_row;
    w_nbit   = r_bit;
    w_nfront = r_front;
    w_load   = r_prime;
    if (!r_prime) begin
      unique case (r_state)
        ST_SHIFT: begin
          if (r_div == DIV_LAST && r_bit != '0) begin
            w_nbit = r_bit - 1'b1;
            w_load = 1'b1;
          end
        end
        ST_DISPLAY: begin
          if (r_cnt == DSP_LAST) begin
            w_nrow = r_row + 1'b1;
            w_nbit = BIT_TOP;
            w_load = 1'b1;
            if (r_row == ROW_LAST)
              w_nfront = r_front ^ swap_req;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < LINES; g++) begin : g_bit
    assign w_raw[g] = w_words[g][w_nbit];
  end

`ifdef CUBE_TEST_PATTERN_EN
  assign w_bits = test_pattern ? '1 : w_raw;
`else
  assign w_bits = w_raw;
`endif

  assign state_out = r_state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= ST_SHIFT;
      r_row           <= '0;
      r_bit           <= BIT_TOP;
      r_div           <= '0;
      r_cnt           <= '0;
      r_front         <= 1'b0;
      r_prime         <= 1'b1;
      serial_clk      <= 1'b0;
      latch_enable    <= 1'b0;
      output_enable_n <= 1'b1;
      row_select_n    <= '1;
      serial_data_out <= '0;
      swap_ack        <= 1'b0;
      frame_start     <= 1'b0;
    end else begin
      frame_start  <= 1'b0;
      swap_ack     <= 1'b0;
      latch_enable <= 1'b0;
      if (w_load)
        serial_data_out <= w_bits;
      // First cycle after reset only primes the data register
      if (r_prime) begin
        r_prime     <= 1'b0;
        frame_start <= 1'b1;
      end else begin
        unique case (r_state)
          ST_SHIFT: begin
            if (r_div == DIV_HALF)
              serial_clk <= 1'b1;
            if (r_div == DIV_LAST) begin
              serial_clk <= 1'b0;
              r_div      <= '0;
              if (r_bit == '0) begin
                r_state         <= ST_BLANK;
                r_cnt           <= '0;
                output_enable_n <= 1'b1;
                serial_data_out <= '0;
              end else begin
                r_bit <= r_bit - 1'b1;
              end
            end else begin
              r_div <= r_div + 1'b1;
            end
          end
          ST_BLANK: begin
            if (r_cnt == BLK_LAST) begin
              r_state      <= ST_LATCH;
              latch_enable <= 1'b1;
              row_select_n <= ~(ROWS'(1) << r_row);
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ST_LATCH: begin
            r_state         <= ST_DISPLAY;
            r_cnt           <= '0;
            output_enable_n <= 1'b0;
          end
          ST_DISPLAY: begin
            if (r_cnt == DSP_LAST) begin
              r_state <= ST_SHIFT;
              r_row   <= w_nrow;
              r_front <= w_nfront;
              r_bit   <= BIT_TOP;
              r_div   <= '0;
              if (r_row == ROW_LAST) begin
                frame_start <= 1'b1;
                swap_ack    <= swap_req;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= ST_SHIFT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cube_panel_scanner.sv
// Directed bench for cube_panel_scanner at default geometry.
module tb_cube_panel_scanner;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [1:0]  wr_panel;
  logic [3:0]  wr_row;
  logic [1:0]  wr_color;
  logic [15:0] wr_data;
  logic        swap_req;
  logic        swap_ack;
  logic        frame_start;
  logic        serial_clk;
  logic        latch_enable;
  logic        output_enable_n;
  logic [11:0] serial_data_out;
  logic [15:0] row_select_n;
  logic [2:0]  state_out;
`ifdef CUBE_TEST_PATTERN_EN
  logic        test_pattern;
`endif

  cube_panel_scanner dut (
    .clk             (clk),
    .reset           (reset),
`ifdef CUBE_TEST_PATTERN_EN
    .test_pattern    (test_pattern),
`endif
    .wr_en           (wr_en),
    .wr_panel        (wr_panel),
    .wr_row          (wr_row),
    .wr_color        (wr_color),
    .wr_data         (wr_data),
    .swap_req        (swap_req),
    .swap_ack        (swap_ack),
    .frame_start     (frame_start),
    .serial_clk      (serial_clk),
    .latch_enable    (latch_enable),
    .output_enable_n (output_enable_n),
    .serial_data_out (serial_data_out),
    .row_select_n    (row_select_n),
    .state_out       (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          p;
    int          r;
    int          c;
    logic [15:0] d;
    int          line;
    int          row;
    logic [15:0] want;
  } vec_t;

  vec_t        tbl [9];
  logic [15:0] mdl [2][12][16];
  logic [15:0] cap [12][16];
  int          mfront;
  int          total;
  int          bad;
  bit          ack_end;
  bit          early_ack;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_write(input int p, input int r, input int c,
                          input logic [15:0] d);
    wr_en    = 1'b1;
    wr_panel = 2'(p);
    wr_row   = 4'(r);
    wr_color = 2'(c);
    wr_data  = d;
    if (c < 3)
      mdl[1-mfront][p*3+c][r] = d;
    @(negedge clk);
  endtask

  task automatic fill_back();
    for (int p = 0; p < 4; p++)
      for (int c = 0; c < 3; c++)
        for (int r = 0; r < 16; r++)
          do_write(p, r, c, 16'h0000);
    wr_en = 1'b0;
  endtask

  task automatic wait_ack(input string name);
    bit found;
    found = 0;
    swap_req = 1'b1;
    for (int k = 0; k < 12000 && !found; k++) begin
      @(negedge clk);
      if (swap_ack) found = 1;
    end
    check(name, {found, frame_start}, 2'b11);
    swap_req = 1'b0;
    if (found) mfront = 1 - mfront;
  endtask

  // Runs from one frame_start to the next, capturing every shifted word
  task automatic capture(input bit at_start);
    int   cyc;
    int   nl;
    int   ne;
    logic prev;
    bit   found;
    ack_end   = 0;
    early_ack = 0;
    for (int l = 0; l < 12; l++)
      for (int r = 0; r < 16; r++)
        cap[l][r] = '0;
    if (!at_start) begin
      found = 0;
      for (int k = 0; k < 6000 && !found; k++) begin
        @(negedge clk);
        if (frame_start) found = 1;
      end
      check("frame_start_seen", found, 1);
      if (!found) return;
    end
    cyc   = 0;
    nl    = 0;
    ne    = 0;
    prev  = serial_clk;
    found = 0;
    for (int k = 0; k < 6000 && !found; k++) begin
      @(negedge clk);
      cyc++;
      if (frame_start) begin
        found = 1;
      end else begin
        if (swap_ack) early_ack = 1;
        if (serial_clk && !prev && ne < 256) begin
          for (int l = 0; l < 12; l++)
            cap[l][ne/16] = {cap[l][ne/16][14:0], serial_data_out[l]};
          ne++;
        end
        if (latch_enable) begin
          check("latch_row", {state_out, output_enable_n, row_select_n},
                {3'd2, 1'b1, ~(16'h0001 << nl)});
          nl++;
        end
      end
      prev = serial_clk;
    end
    ack_end = swap_ack & found;
    check("frame_period", cyc, 5264);
    check("latch_count", nl, 16);
    check("shift_edges", ne, 256);
  endtask

  task automatic frame_cmp(input string name, input int bank);
    int nmis;
    nmis = 0;
    for (int l = 0; l < 12; l++)
      for (int r = 0; r < 16; r++)
        if (cap[l][r] !== mdl[bank][l][r]) begin
          if (nmis == 0)
            $display("%s first diff line %0d row %0d got %h want %h",
                     name, l, r, cap[l][r], mdl[bank][l][r]);
          nmis++;
        end
    check(name, nmis, 0);
  endtask

  initial begin
    tbl[0] = '{2,  0, 1, 16'hA5C3,  7,  0, 16'hA5C3};
    tbl[1] = '{0,  0, 0, 16'h8001,  0,  0, 16'h8001};
    tbl[2] = '{3, 15, 2, 16'hFFFF, 11, 15, 16'h0001};
    tbl[3] = '{1,  7, 0, 16'h0F0F,  3,  7, 16'h0F0F};
    tbl[4] = '{1,  3, 0, 16'h1234,  3,  3, 16'h1234};
    tbl[5] = '{0,  3, 3, 16'hBEEF,  3,  3, 16'h1234};
    tbl[6] = '{2,  9, 2, 16'h5A5A,  8,  9, 16'h5A5A};
    tbl[7] = '{3, 15, 2, 16'h0001, 11, 15, 16'h0001};
    tbl[8] = '{1,  1, 1, 16'hC003,  4,  1, 16'hC003};
    total    = 0;
    bad      = 0;
    mfront   = 0;
    reset    = 1'b1;
    wr_en    = 1'b0;
    wr_panel = '0;
    wr_row   = '0;
    wr_color = '0;
    wr_data  = '0;
    swap_req = 1'b0;
`ifdef CUBE_TEST_PATTERN_EN
    test_pattern = 1'b0;
`endif
    #1;
    check("rst_sclk",  serial_clk, 0);
    check("rst_latch", latch_enable, 0);
    check("rst_oe_n",  output_enable_n, 1);
    check("rst_rowsel", row_select_n, 16'hFFFF);
    check("rst_sdo",   serial_data_out, 12'h000);
    check("rst_ack",   swap_ack, 0);
    check("rst_fs",    frame_start, 0);
    check("rst_state", state_out, 3'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    repeat (10) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst10_oe_n",   output_enable_n, 1);
    check("rst10_rowsel", row_select_n, 16'hFFFF);
    check("rst10_latch",  latch_enable, 0);
    check("rst10_sclk",   serial_clk, 0);
    @(negedge clk);
    reset = 1'b0;

    repeat (40) @(negedge clk);
    check("pre_latch_rowsel", row_select_n, 16'hFFFF);
    check("pre_latch_state",  state_out, 3'd0);

    fill_back();
    wait_ack("init_ack1");
    fill_back();
    for (int i = 0; i < 9; i++)
      do_write(tbl[i].p, tbl[i].r, tbl[i].c, tbl[i].d);
    wr_en = 1'b0;
    wait_ack("init_ack2");

    capture(1);
    frame_cmp("frame_tbl", mfront);
    for (int i = 0; i < 9; i++)
      check($sformatf("tbl%0d_word", i), cap[tbl[i].line][tbl[i].row],
            tbl[i].want);
    check("no_ack_idle", ack_end, 0);

    fork
      capture(1);
      begin : swap_writer
        bit seen;
        seen = 0;
        for (int k = 0; k < 6000 && !seen; k++) begin
          @(negedge clk);
          if (row_select_n == 16'hFFDF) seen = 1;
        end
        check("row5_seen", seen, 1);
        swap_req = 1'b1;
        do_write(2, 0, 1, 16'h3C3C);
        do_write(0, 5, 2, 16'h00F0);
        wr_en = 1'b0;
      end
    join
    check("pre_swap_hidden", cap[7][0], 16'hA5C3);
    frame_cmp("frame_preswap", mfront);
    check("ack_at_boundary", ack_end, 1);
    check("no_early_ack", early_ack, 0);
    swap_req = 1'b0;
    mfront   = 1 - mfront;

    capture(1);
    check("post_swap_word", cap[7][0], 16'h3C3C);
    check("post_swap_word2", cap[2][5], 16'h00F0);
    frame_cmp("frame_postswap", mfront);
    check("no_ack_after_release", ack_end, 0);

    begin : mid_shift_reset
      bit hit;
      hit = 0;
      for (int k = 0; k < 6000 && !hit; k++) begin
        @(negedge clk);
        if (state_out == 3'd0 && serial_clk && !output_enable_n &&
            row_select_n != 16'hFFFF)
          hit = 1;
      end
      check("mid_shift_found", hit, 1);
      #2 reset = 1'b1;
      #1;
      check("rstmid_oe_n",   output_enable_n, 1);
      check("rstmid_rowsel", row_select_n, 16'hFFFF);
      check("rstmid_latch",  latch_enable, 0);
      check("rstmid_sclk",   serial_clk, 0);
      check("rstmid_sdo",    serial_data_out, 12'h000);
      check("rstmid_state",  state_out, 3'd0);
      @(negedge clk);
      reset  = 1'b0;
      mfront = 0;
    end

    capture(0);
    frame_cmp("frame_after_reset", mfront);

`ifdef CUBE_TEST_PATTERN_EN
    begin : tp_check
      int nmis;
      test_pattern = 1'b1;
      capture(1);
      nmis = 0;
      for (int l = 0; l < 12; l++)
        for (int r = 0; r < 16; r++)
          if (cap[l][r] !== 16'hFFFF) nmis++;
      check("test_pattern_ones", nmis, 0);
      test_pattern = 1'b0;
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
